// File: rtl/fib_stream_if.sv
// Stream and status bundle between a Fibonacci term source and its checker.
// The source drives the master side; the checker sits on the slave side.
interface fib_stream_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             restart;
  logic             match;
  logic             err;
  logic [CNT_W-1:0] err_index;
  logic [W-1:0]     err_expected;
  logic             ovf;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_data, restart,
    input  in_ready, match, err, err_index, err_expected, ovf, count
  );

  modport slave (
    input  in_valid, in_data, restart,
    output in_ready, match, err, err_index, err_expected, ovf, count
  );
endinterface

// File: rtl/fib_stream_checker.sv
// Checks an incoming word stream against the Fibonacci sequence 0,1,1,2,...
// Records the first mismatch, counts correct terms and stops when the next term exceeds W bits.
module fib_stream_checker #(
  parameter int W           = 32,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic        clk,
  input  logic        rst,
  fib_stream_if.slave bus
);
  typedef enum logic [2:0] {SEED0, SEED1, RUN, ERR, OVF} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     prev0, prev1;
  logic [W:0]       expected;
  logic             live, accept, hit, miss, sum_ovf;
  logic             rdy_q, rdy_nxt;
  logic             match_q, err_q, ovf_q;
  logic [CNT_W-1:0] count_q, err_index_q;
  logic [W-1:0]     err_expected_q;

  always_comb begin
    expected = '0;
    case (state)
      SEED0:   expected = '0;
      SEED1:   expected = (W+1)'(1);
      default: expected = {1'b0, prev1} + {1'b0, prev0};
    endcase
  end

  assign live   = (state == SEED0) || (state == SEED1) || (state == RUN);
  assign accept = bus.in_valid && rdy_q;
  assign hit    = accept && live && ({1'b0, bus.in_data} == expected);
  assign miss   = accept && live && !hit;
  // Next expected term after this accept is in_data + prev1; a carry into bit W ends the run.
  assign sum_ovf = ({1'b0, bus.in_data} + {1'b0, prev1}) > (W+1)'({W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.restart) state_nxt = SEED0;
    else if (miss)   state_nxt = ERR;
    else if (hit) begin
      case (state)
        SEED0:   state_nxt = SEED1;
        default: state_nxt = sum_ovf ? OVF : RUN;
      endcase
    end
  end

  always_comb begin
    rdy_nxt = 1'b1;
    if (state_nxt == ERR) rdy_nxt = (HALT_ON_ERR == 0);
  end

  // restart wins over a word presented on the same edge: that word is never checked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q          <= 1'b1;
      match_q        <= 1'b0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      count_q        <= '0;
      err_index_q    <= '0;
      err_expected_q <= '0;
      prev0          <= '0;
      prev1          <= '0;
    end else if (bus.restart) begin
      rdy_q          <= 1'b1;
      match_q        <= 1'b0;
      err_q          <= 1'b0;
      ovf_q          <= 1'b0;
      count_q        <= '0;
      err_index_q    <= '0;
      err_expected_q <= '0;
      prev0          <= '0;
      prev1          <= '0;
    end else begin
      rdy_q   <= rdy_nxt;
      match_q <= hit;
      if (hit) begin
        prev0 <= prev1;
        prev1 <= bus.in_data;
        if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
        if (state_nxt == OVF) ovf_q <= 1'b1;
      end
      if (miss) begin
        err_q          <= 1'b1;
        err_index_q    <= count_q;
        err_expected_q <= expected[W-1:0];
      end
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.match        = match_q;
  assign bus.err          = err_q;
  assign bus.ovf          = ovf_q;
  assign bus.count        = count_q;
  assign bus.err_index    = err_index_q;
  assign bus.err_expected = err_expected_q;
endmodule
